// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_pkg : shared types and constants for the shift-add multiplier   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int       N_BITS    = 8;
  localparam logic [2:0] LAST_ITER = 3'd7;

endpackage
`default_nettype wire

// File: rtl/reg_xab.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_xab : 17-bit {X,A,B} register with clear, load and arith. shift  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_xab
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_xa,
  input  logic              load_b,
  input  logic              load_xa,
  input  logic              shift,
  input  logic [N_BITS-1:0] b_in,
  input  logic [N_BITS:0]   xa_in,
  output logic              x,
  output logic [N_BITS-1:0] a,
  output logic [N_BITS-1:0] b
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= 1'b0;
      a <= '0;
      b <= '0;
    end else if (clear_xa) begin
      x <= 1'b0;
      a <= '0;
      if (load_b) b <= b_in;
    end else if (load_xa) begin
      {x, a} <= xa_in;
    end else if (shift) begin
      // X is replicated so the 17-bit value keeps its sign
      {x, a, b} <= {x, x, a, b[N_BITS-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_add_mult_ctrl : 8x8 signed shift-add multiplier controller     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module shift_add_mult_ctrl
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              clear_a_load_b,
  input  logic [N_BITS-1:0] sw,
  input  logic [N_BITS:0]   sum,
  output logic [N_BITS:0]   adder_a,
  output logic [N_BITS:0]   adder_b,
  output logic              adder_fn,
  output logic [N_BITS-1:0] aval,
  output logic [N_BITS-1:0] bval,
  output logic              xval,
  output logic              done
);

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       clear_xa, load_b, load_xa, shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clear_xa   = 1'b0;
    load_b     = 1'b0;
    load_xa    = 1'b0;
    shift      = 1'b0;
    adder_fn   = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          clear_xa   = 1'b1;
          cnt_next   = 3'd0;
          state_next = ADD;
        end else if (clear_a_load_b) begin
          clear_xa = 1'b1;
          load_b   = 1'b1;
        end
      end
      ADD: begin
        // The multiplier's sign bit carries negative weight, hence subtract
        adder_fn   = (cnt == LAST_ITER);
        load_xa    = bval[0];
        state_next = SHIFT;
      end
      SHIFT: begin
        shift      = 1'b1;
        cnt_next   = cnt + 3'd1;
        state_next = (cnt == LAST_ITER) ? DONE : ADD;
      end
      DONE: begin
        if (!run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign adder_a = {aval[N_BITS-1], aval};
  assign adder_b = {sw[N_BITS-1], sw};

  reg_xab u_reg_xab (
    .clk      (clk),
    .reset    (reset),
    .clear_xa (clear_xa),
    .load_b   (load_b),
    .load_xa  (load_xa),
    .shift    (shift),
    .b_in     (sw),
    .xa_in    (sum),
    .x        (xval),
    .a        (aval),
    .b        (bval)
  );

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_add_mult_ctrl : self-checking bench for the multiplier      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_shift_add_mult_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       clear_a_load_b;
  logic [7:0] sw;
  logic [8:0] sum;
  logic [8:0] adder_a, adder_b;
  logic       adder_fn;
  logic [7:0] aval, bval;
  logic       xval, done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // external combinational 9-bit adder/subtractor
  assign sum = adder_fn ? (adder_a - adder_b) : (adder_a + adder_b);

  shift_add_mult_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .clear_a_load_b (clear_a_load_b),
    .sw             (sw),
    .sum            (sum),
    .adder_a        (adder_a),
    .adder_b        (adder_b),
    .adder_fn       (adder_fn),
    .aval           (aval),
    .bval           (bval),
    .xval           (xval),
    .done           (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] prod16(input logic [7:0] b, input logic [7:0] s);
    int sb, ss, p;
    sb = $signed(b);
    ss = $signed(s);
    p  = sb * ss;
    return p[15:0];
  endfunction

  // Behavioural model: mode 0 = waiting, 1 = multiplying, 2 = result held
  int         m_mode;
  int         m_k;
  logic [7:0] m_a, m_b;
  logic       m_x;
  logic [15:0] m_p;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0; m_k <= 0; m_a <= 8'h00; m_b <= 8'h00; m_x <= 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (run) begin
            m_mode <= 1; m_k <= 0; m_a <= 8'h00; m_x <= 1'b0;
          end else if (clear_a_load_b) begin
            m_a <= 8'h00; m_x <= 1'b0; m_b <= sw;
          end
        end
        1: begin
          if (m_k == 15) begin
            m_p = prod16(m_b, sw);
            m_a <= m_p[15:8]; m_b <= m_p[7:0]; m_x <= m_p[15]; m_mode <= 2;
          end else begin
            m_k <= m_k + 1;
          end
        end
        default: if (!run) m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("done", done, (m_mode == 2));
      check("adder_fn", adder_fn, (m_mode == 1 && m_k == 14));
      check("adder_b", adder_b, {sw[7], sw});
      if (m_mode != 1) begin
        check("aval", aval, m_a);
        check("bval", bval, m_b);
        check("xval", xval, m_x);
        check("adder_a", adder_a, {m_a[7], m_a});
      end
    end
  end

  task automatic load_b(input logic [7:0] v);
    @(negedge clk); #1;
    sw = v; clear_a_load_b = 1'b1;
    @(negedge clk); #1;
    clear_a_load_b = 1'b0;
  endtask

  // run is raised and left high; waits up to 40 edges for done
  task automatic run_and_wait(input logic [7:0] s, output int edges, output int fn_cnt);
    sw = s; run = 1'b1;
    edges = 0; fn_cnt = 0;
    while (!done && edges < 40) begin
      @(posedge clk); edges++; #1;
      if (adder_fn) fn_cnt++;
    end
  endtask

  task automatic mult(input logic [7:0] b, input logic [7:0] s,
                      input logic [7:0] ea, input logic [7:0] eb, input logic ex);
    int edges, fn_cnt;
    load_b(b);
    run_and_wait(s, edges, fn_cnt);
    check("latency", edges, 17);
    check("lit_done", done, 1'b1);
    check("lit_aval", aval, ea);
    check("lit_bval", bval, eb);
    check("lit_xval", xval, ex);
    check("fn_cycles", fn_cnt, 1);
    @(negedge clk); #1;
    run = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    int edges, fn_cnt;
    reset = 1'b1; run = 1'b0; clear_a_load_b = 1'b0; sw = 8'h5A;
    #1;
    check("rst_aval", aval, 8'h00);
    check("rst_bval", bval, 8'h00);
    check("rst_xval", xval, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_adder_a", adder_a, 9'h000);
    check("rst_adder_b", adder_b, 9'h05A);
    check("rst_adder_fn", adder_fn, 1'b0);
    @(negedge clk); #2;
    reset = 1'b0;

    // positive case, then hold run high through done
    load_b(8'h07);
    run_and_wait(8'h3B, edges, fn_cnt);
    check("latency", edges, 17);
    check("pos_aval", aval, 8'h01);
    check("pos_bval", bval, 8'h9D);
    check("pos_xval", xval, 1'b0);
    check("pos_fn_cycles", fn_cnt, 1);
    repeat (4) begin
      @(posedge clk); #1;
      check("hold_done", done, 1'b1);
      check("hold_aval", aval, 8'h01);
    end
    run = 1'b0;
    @(posedge clk); #1;
    check("release_done", done, 1'b0);
    // restart multiplies the previous low byte 0x9D (-99) by 0x3B (59)
    run_and_wait(8'h3B, edges, fn_cnt);
    check("restart_latency", edges, 17);
    check("restart_aval", aval, 8'hE9);
    check("restart_bval", bval, 8'h2F);
    check("restart_xval", xval, 1'b1);
    @(negedge clk); #1; run = 1'b0;

    mult(8'hFD, 8'h07, 8'hFF, 8'hEB, 1'b1);
    mult(8'h80, 8'h80, 8'h40, 8'h00, 1'b0);
    mult(8'h00, 8'h5A, 8'h00, 8'h00, 1'b0);
    mult(8'h7F, 8'h81, 8'hC0, 8'hFF, 1'b1);
    mult(8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0);

    // reset asserted during the third SHIFT cycle
    load_b(8'h55);
    sw = 8'h33; run = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2; reset = 1'b1; run = 1'b0;
    #1;
    check("abort_aval", aval, 8'h00);
    check("abort_bval", bval, 8'h00);
    check("abort_xval", xval, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_fn", adder_fn, 1'b0);
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_abort_done", done, 1'b0);
    check("post_abort_aval", aval, 8'h00);

    // clear_a_load_b raised during ADD must not disturb the multiply
    load_b(8'h0B);
    sw = 8'h13; run = 1'b1;
    @(posedge clk); #1;
    clear_a_load_b = 1'b1;
    @(posedge clk); #1;
    clear_a_load_b = 1'b0;
    run_and_wait(8'h13, edges, fn_cnt);
    check("clr_ign_aval", aval, 8'h00);
    check("clr_ign_bval", bval, 8'hD1);
    check("clr_ign_done", done, 1'b1);
    @(negedge clk); #1; run = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
